// File: rtl/seven_seg_scan_ctrl.sv
// Scan controller for an N-digit common-anode 7-segment display: one digit lit at a time with a dead-time
// blank between digits; frame writes via ready/valid, committed only at frame boundaries so a scan never tears.
module seven_seg_scan_ctrl #(
  parameter int NUM_DIGITS   = 4,
  parameter int REFRESH_DIV  = 50000,
  parameter int BLANK_CYCLES = 500
) (
  input  logic                    CLK,
  input  logic                    RST,
  input  logic                    wr_valid,
  input  logic [4*NUM_DIGITS-1:0] wr_data,
  input  logic                    lzb_en,
  output logic                    wr_ready,
  output logic                    commit,
  output logic [3:0]              digit_value,
  output logic                    seg_blank,
  output logic [NUM_DIGITS-1:0]   anode_n
);

  localparam int CNT_MAX = (REFRESH_DIV > BLANK_CYCLES) ? REFRESH_DIV : BLANK_CYCLES;
  localparam int CW      = (CNT_MAX > 1) ? $clog2(CNT_MAX) : 1;
  localparam int IW      = $clog2(NUM_DIGITS);
  localparam int DW      = 4 * NUM_DIGITS;

  localparam logic [CW-1:0] SHOW_LAST  = CW'(REFRESH_DIV - 1);
  localparam logic [CW-1:0] BLANK_LAST = CW'(BLANK_CYCLES - 1);
  localparam logic [IW-1:0] IDX_LAST   = IW'(NUM_DIGITS - 1);

  typedef enum logic {BLANK, SHOW} state_t;

  state_t          state, state_nxt;
  logic [CW-1:0]   cnt, cnt_nxt;
  logic [IW-1:0]   idx, idx_nxt;
  logic            boundary;
  logic            do_commit;
  logic [DW-1:0]   active, pending, frame_nxt;
  logic [NUM_DIGITS-1:0] lz_blank;
  logic            zero_run;
  logic            digit_off;
  logic [3:0]      nib_nxt;
  logic [NUM_DIGITS-1:0] anode_nxt;
  logic            seg_nxt;
  logic [3:0]      dv_nxt;

  always_comb begin
    state_nxt = state;
    cnt_nxt   = cnt + CW'(1);
    idx_nxt   = idx;
    boundary  = 1'b0;
    case (state)
      SHOW: begin
        if (cnt == SHOW_LAST) begin
          cnt_nxt   = '0;
          state_nxt = BLANK;
        end
      end
      default: begin
        if (cnt == BLANK_LAST) begin
          cnt_nxt   = '0;
          state_nxt = SHOW;
          if (idx == IDX_LAST) begin
            idx_nxt  = '0;
            boundary = 1'b1;
          end else begin
            idx_nxt = idx + IW'(1);
          end
        end
      end
    endcase
  end

  // A commit is only possible one frame after the previous one, so !wr_ready alone marks a held write.
  assign do_commit = boundary & ~wr_ready & ~commit;
  assign frame_nxt = do_commit ? pending : active;

  // Output decode looks at the frame that will be active after this edge, so the first digit of a
  // freshly committed frame already shows the new value.
  always_comb begin
    zero_run = 1'b1;
    lz_blank = '0;
    for (int k = NUM_DIGITS - 1; k >= 1; k--) begin
      zero_run    = zero_run & (frame_nxt[4*k +: 4] == 4'h0);
      lz_blank[k] = zero_run;
    end
  end

  assign digit_off = lzb_en & lz_blank[idx_nxt];
  assign nib_nxt   = frame_nxt[{idx_nxt, 2'b00} +: 4];

  always_comb begin
    anode_nxt = '1;
    seg_nxt   = 1'b1;
    dv_nxt    = digit_value;
    if (state_nxt == SHOW) begin
      dv_nxt = nib_nxt;
      if (!digit_off) begin
        anode_nxt = ~(NUM_DIGITS'(1) << idx_nxt);
        seg_nxt   = 1'b0;
      end
    end
  end

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      state       <= BLANK;
      cnt         <= '0;
      idx         <= IDX_LAST;
      anode_n     <= '1;
      seg_blank   <= 1'b1;
      digit_value <= 4'h0;
    end else begin
      state       <= state_nxt;
      cnt         <= cnt_nxt;
      idx         <= idx_nxt;
      anode_n     <= anode_nxt;
      seg_blank   <= seg_nxt;
      digit_value <= dv_nxt;
    end
  end

  // wr_ready reopens the cycle after the commit pulse, so it is low for the whole commit cycle.
  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      wr_ready <= 1'b1;
      commit   <= 1'b0;
      active   <= '0;
      pending  <= '0;
    end else begin
      commit <= do_commit;
      if (commit) begin
        wr_ready <= 1'b1;
      end else if (do_commit) begin
        active <= pending;
      end else if (wr_valid && wr_ready) begin
        pending  <= wr_data;
        wr_ready <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_seven_seg_scan_ctrl.sv
// Directed bench for seven_seg_scan_ctrl with NUM_DIGITS=4, REFRESH_DIV=4, BLANK_CYCLES=2 (24-cycle frame).
module tb_seven_seg_scan_ctrl;

  logic        CLK = 1'b0;
  logic        RST = 1'b1;
  logic        wr_valid = 1'b0;
  logic [15:0] wr_data = 16'h0;
  logic        lzb_en = 1'b0;
  logic        wr_ready;
  logic        commit;
  logic [3:0]  digit_value;
  logic        seg_blank;
  logic [3:0]  anode_n;

  int cyc = 0;
  int total = 0;
  int passed = 0;
  int fails = 0;

  seven_seg_scan_ctrl #(.NUM_DIGITS(4), .REFRESH_DIV(4), .BLANK_CYCLES(2)) dut (
    .CLK(CLK), .RST(RST), .wr_valid(wr_valid), .wr_data(wr_data), .lzb_en(lzb_en),
    .wr_ready(wr_ready), .commit(commit), .digit_value(digit_value),
    .seg_blank(seg_blank), .anode_n(anode_n)
  );

  always #5 CLK = ~CLK;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) passed++;
    else begin
      fails++;
      $error("FAIL %s (cycle %0d): observed %0h expected %0h", tag, cyc, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge CLK);
    #1;
    cyc++;
  endtask

  task automatic run_to(input int n);
    while (cyc < n) tick();
  endtask

  // Cycle 0 is the period between reset release (at a falling edge) and the next rising edge.
  task automatic release_reset();
    @(negedge CLK);
    RST = 1'b0;
    cyc = 0;
  endtask

  task automatic write(input logic [15:0] d);
    wr_valid = 1'b1;
    wr_data  = d;
    tick();
    wr_valid = 1'b0;
  endtask

  int  gap;
  int  bad_scan;
  logic [3:0] last_lit;

  initial begin
    repeat (2) @(negedge CLK);
    release_reset();
    chk("rst_anode", anode_n, 4'b1111);
    chk("rst_segblank", seg_blank, 1'b1);
    chk("rst_value", digit_value, 4'h0);
    chk("rst_ready", wr_ready, 1'b1);
    chk("rst_commit", commit, 1'b0);

    run_to(1);
    chk("blank_c1", anode_n, 4'b1111);
    run_to(2);
    chk("d0_anode_c2", anode_n, 4'b1110);
    chk("d0_segblank_c2", seg_blank, 1'b0);
    chk("d0_value_c2", digit_value, 4'h0);

    run_to(5);
    write(16'h1234);
    chk("ready_low_c6", wr_ready, 1'b0);
    chk("blank_c6", anode_n, 4'b1111);
    run_to(8);
    chk("d1_anode_c8", anode_n, 4'b1101);
    chk("d1_old_value_c8", digit_value, 4'h0);
    run_to(10);
    write(16'hFFFF);
    chk("ready_still_low", wr_ready, 1'b0);
    run_to(20);
    chk("d3_anode_c20", anode_n, 4'b0111);
    run_to(25);
    chk("no_commit_c25", commit, 1'b0);
    run_to(26);
    chk("commit_c26", commit, 1'b1);
    chk("ready_in_commit", wr_ready, 1'b0);
    chk("d0_anode_c26", anode_n, 4'b1110);
    chk("d0_value_c26", digit_value, 4'h4);
    run_to(27);
    chk("commit_end_c27", commit, 1'b0);
    chk("ready_back_c27", wr_ready, 1'b1);
    run_to(32);
    chk("d1_value_c32", digit_value, 4'h3);
    run_to(38);
    chk("d2_anode_c38", anode_n, 4'b1011);
    chk("d2_value_c38", digit_value, 4'h2);
    run_to(44);
    chk("d3_value_c44", digit_value, 4'h1);
    run_to(50);
    chk("ffff_ignored", digit_value, 4'h4);

    lzb_en = 1'b1;
    write(16'h0070);
    run_to(74);
    chk("commit_c74", commit, 1'b1);
    chk("lz_d0_anode", anode_n, 4'b1110);
    chk("lz_d0_value", digit_value, 4'h0);
    run_to(80);
    chk("lz_d1_anode", anode_n, 4'b1101);
    chk("lz_d1_value", digit_value, 4'h7);
    run_to(86);
    chk("lz_d2_off", anode_n, 4'b1111);
    chk("lz_d2_segblank", seg_blank, 1'b1);
    run_to(92);
    chk("lz_d3_off", anode_n, 4'b1111);
    write(16'h0000);
    run_to(98);
    chk("zero_d0_anode", anode_n, 4'b1110);
    chk("zero_d0_value", digit_value, 4'h0);
    chk("zero_d0_segblank", seg_blank, 1'b0);
    run_to(104);
    chk("zero_d1_off", anode_n, 4'b1111);

    lzb_en = 1'b0;
    write(16'hABCD);
    chk("abcd_pending", wr_ready, 1'b0);
    run_to(111);
    chk("d2_lit_before_rst", anode_n, 4'b1011);
    #2;
    RST = 1'b1;
    #1;
    chk("arst_anode", anode_n, 4'b1111);
    chk("arst_segblank", seg_blank, 1'b1);
    chk("arst_value", digit_value, 4'h0);
    chk("arst_ready", wr_ready, 1'b1);
    chk("arst_commit", commit, 1'b0);
    release_reset();
    run_to(8);
    chk("post_rst_d1_value", digit_value, 4'h0);
    run_to(26);
    chk("post_rst_no_commit", commit, 1'b0);
    chk("post_rst_d0_value", digit_value, 4'h0);

    write(16'h5A0C);
    gap = 100;
    bad_scan = 0;
    last_lit = 4'b1111;
    for (int i = 0; i < 1000; i++) begin
      tick();
      if (i == 300) lzb_en = 1'b1;
      if (anode_n != 4'b1111) begin
        if ($countones(~anode_n) != 1) bad_scan++;
        if (anode_n != last_lit && last_lit != 4'b1111 && gap < 2) bad_scan++;
        last_lit = anode_n;
        gap = 0;
      end else begin
        gap++;
      end
    end
    chk("scan_onehot_deadtime", bad_scan, 0);

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: observed no finish, required finish before time limit");
    $fatal(1, "timeout");
  end

endmodule
